// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one synchronous FIFO write
// port among NUM_REQ producers. A winner keeps the grant for up to MAX_BURST
// consecutive words before the grant rotates.
// Grants are combinational: a word is accepted in the same cycle it is offered.
// A full FIFO stalls every producer and freezes all arbiter state.
// Optional macro FIFO_ARB_STATS_EN adds saturating per-requester grant
// counters and a stall counter.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [IW-1:0]            owner,
  output logic                     locked
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [BW-1:0]   burst_cnt;

  logic            win_ok;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_nxt;
  logic            keep;
  logic            take;
  logic [IW-1:0]   sel;
  int              idx;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_ok = 1'b0;
    win    = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_ok && req[idx]) begin
        win_ok = 1'b1;
        win    = IW'(idx);
      end
    end
  end

  assign win_nxt = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);

  // The lock holds only while the owner keeps requesting and has budget left;
  // otherwise the lock is dropped this cycle and the RR winner is taken.
  assign keep = (state == LOCKED) && req[owner] && (burst_cnt < MAX_B);
  assign take = !rst && !fifo_full && (keep || win_ok);
  assign sel  = keep ? owner : win;

  // Grant decode and write-port mux; everything zero when nothing is accepted.
  always_comb begin
    gnt          = '0;
    fifo_data_in = '0;
    if (take) begin
      gnt[sel]     = 1'b1;
      fifo_data_in = req_data[int'(sel)*WIDTH +: WIDTH];
    end
  end

  assign fifo_write = take;
  assign locked     = (state == LOCKED);

  // Arbiter FSM: lock tracking, burst budget and rotation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (!fifo_full) begin
      if (keep) begin
        burst_cnt <= burst_cnt + BW'(1);
        if (burst_cnt + BW'(1) == MAX_B) state <= IDLE;
      end else if (win_ok) begin
        owner     <= win;
        burst_cnt <= BW'(1);
        rr_ptr    <= win_nxt;
        state     <= (MAX_BURST > 1) ? LOCKED : IDLE;
      end else begin
        state <= IDLE;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating grant counters per requester and a stall counter for
  // cycles where someone wanted to write but the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if ((|req) && fifo_full && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
